// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared BCD constants and the nibble clamp helper used by the counter.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package bcd_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  // Saturate a raw nibble into the legal BCD range 0..9.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_counter_n_if.sv
// ---------------------------------------------------------------------------
// bcd_counter_n_if
// Control/status bundle of the N-digit BCD counter. The master side drives
// clear/load/enable/direction, the slave side (the counter) returns the
// count, terminal count and load error flag.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface bcd_counter_n_if #(
  parameter int unsigned DIGITS = 2
);

  logic                  clr;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  en;
  logic                  up_dn;
  logic [4*DIGITS-1:0]   cnt;
  logic                  tc;
  logic                  load_err;

  modport master (
    output clr, load, load_val, en, up_dn,
    input  cnt, tc, load_err
  );

  modport slave (
    input  clr, load, load_val, en, up_dn,
    output cnt, tc, load_err
  );

endinterface

`default_nettype wire

// File: rtl/bcd_counter_n_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit
// One combinational BCD digit slice: next value and carry/borrow out for a
// given carry/borrow in and direction. Holds no state.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_digit
  import bcd_pkg::*;
(
  input  wire logic [BCD_W-1:0] cur,
  input  wire logic             up_dn,
  input  wire logic             cin,
  output logic      [BCD_W-1:0] nxt,
  output logic                  cout
);

  // Step the digit only when a carry/borrow arrives; roll over at 9 / 0.
  always_comb begin
    nxt  = cur;
    cout = 1'b0;
    if (cin) begin
      if (up_dn) begin
        if (cur >= BCD_MAX) begin
          nxt  = '0;
          cout = 1'b1;
        end else begin
          nxt = cur + 4'd1;
        end
      end else begin
        if (cur == '0) begin
          nxt  = BCD_MAX;
          cout = 1'b1;
        end else begin
          nxt = cur - 4'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_counter_n.sv
// ---------------------------------------------------------------------------
// bcd_counter_n
// N-digit packed BCD up/down counter with synchronous clear, clamped
// parallel load, count enable and a combinational terminal count for
// cascading. Carry/borrow ripples through all digits in a single cycle.
// Build option: define BCD_COUNTER_SAT_EN to saturate at all-9s / all-0s
// instead of wrapping.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int unsigned         DIGITS  = 2,
  parameter logic [4*DIGITS-1:0] RST_VAL = '0
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  bcd_counter_n_if.slave   bus
);

  localparam int unsigned W = BCD_W * DIGITS;

  // Reject illegal configurations at elaboration.
  if ((DIGITS < 1) || (DIGITS > 8)) begin : g_digits_chk
    $error("bcd_counter_n: DIGITS must be in 1..8");
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_rst_chk
    if (RST_VAL[BCD_W*g +: BCD_W] > BCD_MAX) begin : g_bad
      $error("bcd_counter_n: RST_VAL nibble exceeds 9");
    end
  end

  logic [W-1:0]      cnt_q, cnt_d;
  logic              load_err_q, load_err_d;

  logic [W-1:0]      w_step;      // count value one step away in current direction
  logic [DIGITS:0]   w_carry;     // carry/borrow chain, bit 0 is the LSD input
  logic [W-1:0]      w_load;      // load value with each nibble clamped to 9
  logic [DIGITS-1:0] w_over;      // per-nibble "load nibble was >9"
  logic              w_wrap;      // chain ran off the top: at all-9s up / all-0s down

  assign w_carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .cur   (cnt_q[BCD_W*g +: BCD_W]),
      .up_dn (bus.up_dn),
      .cin   (w_carry[g]),
      .nxt   (w_step[BCD_W*g +: BCD_W]),
      .cout  (w_carry[g+1])
    );

    assign w_load[BCD_W*g +: BCD_W] = bcd_clamp(bus.load_val[BCD_W*g +: BCD_W]);
    assign w_over[g]                = (bus.load_val[BCD_W*g +: BCD_W] > BCD_MAX);
  end

  // A carry out of the top digit only happens when every digit is at the
  // boundary for the current direction, so it doubles as the tc condition.
  assign w_wrap = w_carry[DIGITS];

  // Next-state selection with clr > load > en priority.
  always_comb begin
    cnt_d      = cnt_q;
    load_err_d = 1'b0;
    if (bus.clr) begin
      cnt_d = RST_VAL;
    end else if (bus.load) begin
      cnt_d      = w_load;
      load_err_d = |w_over;
    end else if (bus.en) begin
`ifdef BCD_COUNTER_SAT_EN
      if (!w_wrap) begin
        cnt_d = w_step;
      end
`else
      cnt_d = w_step;
`endif
    end
  end

  // Count and error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= RST_VAL;
      load_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.cnt      = cnt_q;
  assign bus.load_err = load_err_q;
  assign bus.tc       = bus.en & w_wrap;

endmodule

`default_nettype wire
